// File: rtl/multicycle_controller.sv
// Control FSM for the shared single-ALU RV32I datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// runs the imem/dmem req/ready handshakes and drives the per-cycle enables and mux selects.
module multicycle_controller #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  // Last wait cycle index: a ready seen here still wins over the timeout.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          cur;
  logic [TO_W-1:0] cnt;

  logic [6:0] opcode;
  logic       is_r, is_i, is_b, is_load, is_store, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic       rd_zero;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign rd_zero     = (instr[11:7] == 5'd0);
  assign unused_bits = ^instr[31:12];
  assign state       = cur;

  always_comb begin
    is_r     = (opcode == OPCODE_OP);
    is_i     = (opcode == OPCODE_OPIMM);
    is_b     = (opcode == OPCODE_BRANCH);
    is_load  = (opcode == OPCODE_LOAD);
    is_store = (opcode == OPCODE_STORE);
    is_jal   = (opcode == OPCODE_JAL);
    is_jalr  = (opcode == OPCODE_JALR);
    is_lui   = (opcode == OPCODE_LUI);
    is_auipc = (opcode == OPCODE_AUIPC);
    legal    = is_r | is_i | is_b | is_load | is_store | is_jal | is_jalr | is_lui | is_auipc;
  end

  // Sequencing and wait-cycle counter; the counter restarts on every entry to FETCH or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
      cnt <= '0;
    end else begin
      case (cur)
        S_IDLE: begin
          cur <= S_FETCH;
          cnt <= '0;
        end
        S_FETCH: begin
          if (imem_ready)          cur <= S_DECODE;
          else if (cnt == TO_LAST) cur <= S_FAULT;
          else                     cnt <= cnt + 1'b1;
        end
        S_DECODE: cur <= legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (is_b) begin
            cur <= S_FETCH;
            cnt <= '0;
          end else if (is_load || is_store) begin
            cur <= S_MEM;
            cnt <= '0;
          end else begin
            cur <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (is_store) begin
              cur <= S_FETCH;
              cnt <= '0;
            end else begin
              cur <= S_WB;
            end
          end else if (cnt == TO_LAST) begin
            cur <= S_FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          cur <= S_FETCH;
          cnt <= '0;
        end
        S_TRAP:  cur <= S_TRAP;
        S_FAULT: cur <= S_FAULT;
      endcase
    end
  end

  // Outputs decode straight from the state so an async reset drops requests immediately.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    reg_we   = 1'b0;
    wb_sel   = 2'b00;
    alu_src  = 1'b0;
    alu_op   = 2'b01;
    illegal  = 1'b0;
    fault    = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        alu_src = !(is_r || is_b);
        if (is_r)      alu_op = 2'b00;
        else if (is_i) alu_op = 2'b10;
        else if (is_b) alu_op = 2'b11;
        if (is_b) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        pc_we    = is_store && dmem_ready;
      end
      S_WB: begin
        reg_we = !rd_zero;
        if (is_load)                wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        pc_we = 1'b1;
        if (is_jal)       pc_sel = 2'b01;
        else if (is_jalr) pc_sel = 2'b10;
      end
      S_TRAP:  illegal = 1'b1;
      S_FAULT: fault   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: the stimulus thread pushes a hand-computed output vector for each cycle,
// a negedge monitor pops it and compares it against the full DUT output vector.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        branch_taken;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        ir_we, pc_we, reg_we, alu_src, illegal, fault;
  logic [1:0]  pc_sel, wb_sel, alu_op;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1, x0, 5
  localparam logic [31:0] I_LW   = 32'h0000A103;  // lw   x2, 0(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1, x2, 8
  localparam logic [31:0] I_JALR = 32'h000280E7;  // jalr x1, 0(x5)
  localparam logic [31:0] I_ADD0 = 32'h00208033;  // add  x0, x1, x2
  localparam logic [31:0] I_SW   = 32'h0020A223;  // sw   x2, 4(x1)
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
    .illegal(illegal), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Packing: {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src, alu_op, illegal, fault}
  function automatic logic [17:0] ev(logic [2:0] st, logic ir, logic dr, logic dw, logic irw,
                                      logic pcw, logic [1:0] pcs, logic rw, logic [1:0] wbs,
                                      logic as, logic [1:0] ao, logic il, logic ft);
    return {st, ir, dr, dw, irw, pcw, pcs, rw, wbs, as, ao, il, ft};
  endfunction

  function automatic logic [17:0] v_idle();
    return ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 0, 0);
  endfunction
  function automatic logic [17:0] v_fetch(logic irw);
    return ev(3'd1, 1, 0, 0, irw, 0, 2'b00, 0, 2'b00, 0, 2'b01, 0, 0);
  endfunction
  function automatic logic [17:0] v_decode();
    return ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 0, 0);
  endfunction
  function automatic logic [17:0] v_exec(logic pcw, logic [1:0] pcs, logic as, logic [1:0] ao);
    return ev(3'd3, 0, 0, 0, 0, pcw, pcs, 0, 2'b00, as, ao, 0, 0);
  endfunction
  function automatic logic [17:0] v_mem(logic dw, logic pcw);
    return ev(3'd4, 0, 1, dw, 0, pcw, 2'b00, 0, 2'b00, 0, 2'b01, 0, 0);
  endfunction
  function automatic logic [17:0] v_wb(logic rw, logic [1:0] wbs, logic [1:0] pcs);
    return ev(3'd5, 0, 0, 0, 0, 1, pcs, rw, wbs, 0, 2'b01, 0, 0);
  endfunction
  function automatic logic [17:0] v_trap();
    return ev(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 1, 0);
  endfunction
  function automatic logic [17:0] v_fault();
    return ev(3'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 0, 1);
  endfunction

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Push the expectation for the current cycle, then move to 1 time unit past the next edge.
  task automatic cyc(string name, logic [17:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name,
            {14'd0, state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel,
             alu_src, alu_op, illegal, fault},
            {14'd0, e.v});
    end
  end

  initial begin
    rst_n        = 1'b0;
    instr        = I_ADDI;
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    dmem_ready   = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", v_idle());
    rst_n = 1'b1;
    cyc("idle_after_release", v_idle());

    // addi x1, x0, 5
    cyc("addi_fetch", v_fetch(1));
    cyc("addi_decode", v_decode());
    cyc("addi_exec", v_exec(0, 2'b00, 1, 2'b10));
    cyc("addi_wb", v_wb(1, 2'b00, 2'b00));

    // lw with dmem_ready after 3 wait cycles
    instr = I_LW;
    cyc("lw_fetch", v_fetch(1));
    cyc("lw_decode", v_decode());
    cyc("lw_exec", v_exec(0, 2'b00, 1, 2'b01));
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", v_mem(0, 0));
    dmem_ready = 1'b1;
    cyc("lw_mem_ready", v_mem(0, 0));
    dmem_ready = 1'b0;
    cyc("lw_wb", v_wb(1, 2'b01, 2'b00));

    // beq taken, then not taken
    instr        = I_BEQ;
    branch_taken = 1'b1;
    cyc("beq_t_fetch", v_fetch(1));
    cyc("beq_t_decode", v_decode());
    cyc("beq_t_exec", v_exec(1, 2'b01, 0, 2'b11));
    branch_taken = 1'b0;
    cyc("beq_n_fetch", v_fetch(1));
    cyc("beq_n_decode", v_decode());
    cyc("beq_n_exec", v_exec(1, 2'b00, 0, 2'b11));

    // jalr x1, 0(x5) then add x0, x1, x2
    instr = I_JALR;
    cyc("jalr_fetch", v_fetch(1));
    cyc("jalr_decode", v_decode());
    cyc("jalr_exec", v_exec(0, 2'b00, 1, 2'b01));
    cyc("jalr_wb", v_wb(1, 2'b10, 2'b10));
    instr = I_ADD0;
    cyc("add_fetch", v_fetch(1));
    cyc("add_decode", v_decode());
    cyc("add_exec", v_exec(0, 2'b00, 0, 2'b00));
    cyc("add_x0_wb", v_wb(0, 2'b00, 2'b00));

    // sw with one fetch wait cycle and zero-wait data access
    instr      = I_SW;
    imem_ready = 1'b0;
    cyc("sw_fetch_wait", v_fetch(0));
    imem_ready = 1'b1;
    cyc("sw_fetch", v_fetch(1));
    cyc("sw_decode", v_decode());
    cyc("sw_exec", v_exec(0, 2'b00, 1, 2'b01));
    dmem_ready = 1'b1;
    cyc("sw_mem", v_mem(1, 1));
    dmem_ready = 1'b0;

    // illegal opcode: TRAP holds, stray readies ignored
    instr = I_BAD;
    cyc("bad_fetch", v_fetch(1));
    cyc("bad_decode", v_decode());
    for (int i = 0; i < 20; i++) begin
      dmem_ready = (i % 3 == 0);
      cyc("trap_hold", v_trap());
    end
    dmem_ready = 1'b0;
    rst_n = 1'b0;
    cyc("trap_reset", v_idle());
    rst_n = 1'b1;
    instr = I_ADDI;
    cyc("idle_after_trap", v_idle());

    // ready arriving on the last permitted wait cycle still wins
    imem_ready = 1'b0;
    for (int i = 0; i < 254; i++) cyc("fetch_wait_edge", v_fetch(0));
    imem_ready = 1'b1;
    cyc("fetch_ready_at_limit", v_fetch(1));
    imem_ready = 1'b0;
    cyc("edge_decode", v_decode());
    cyc("edge_exec", v_exec(0, 2'b00, 1, 2'b10));
    cyc("edge_wb", v_wb(1, 2'b00, 2'b00));

    // fetch timeout into FAULT
    for (int i = 0; i < 255; i++) cyc("fetch_wait_to", v_fetch(0));
    for (int i = 0; i < 4; i++) begin
      imem_ready = (i >= 2);
      cyc("fault_hold", v_fault());
    end
    rst_n = 1'b0;
    cyc("fault_reset", v_idle());
    rst_n = 1'b1;
    cyc("idle_after_fault", v_idle());

    // async reset in the middle of a MEM wait
    instr      = I_LW;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    cyc("lw2_fetch", v_fetch(1));
    cyc("lw2_decode", v_decode());
    cyc("lw2_exec", v_exec(0, 2'b00, 1, 2'b01));
    check("mem_req_before_reset", {31'd0, dmem_req}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("dmem_req_async_drop", {31'd0, dmem_req}, 32'd0);
    check("state_async_idle", {29'd0, state}, 32'd0);
    cyc("mem_reset_idle", v_idle());
    rst_n = 1'b1;
    cyc("idle_after_mem_reset", v_idle());
    cyc("fetch_after_mem_reset", v_fetch(1));

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the shared single-ALU RV32I datapath over FETCH/DECODE/EXEC/MEM/WB cycles.
- Handles the instruction-memory and data-memory req/ready handshakes.
- Produces the per-cycle write enables and mux selects from the held instruction. Its static control encoding matches the main decoder.
- Sits between the memory interfaces and the datapath: PC, IR, register file, ALU and the branch comparator.

Parameters:
- TIMEOUT, 255, max cycles waiting for any ready before entering FAULT.
- TO_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  IR contents, stable from DECODE onward.
- branch_taken  in  1  comparator result, sampled in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ready  in  1  data access complete this cycle.
- ir_we  out  1  latch fetched instruction into IR.
- pc_we  out  1  update PC.
- pc_sel  out  2  00 = PC+4, 01 = PC+imm (branch/JAL), 10 = ALU result & ~1 (JALR).
- reg_we  out  1  register file write.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- alu_src  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  00 = R, 10 = I-arith, 11 = branch, 01 = add.
- illegal  out  1  sticky: unknown opcode seen.
- fault  out  1  sticky: memory timeout.
- state  out  3  debug encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6, FAULT 7.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, timeout counter = 0.
  - All outputs 0; alu_op = 01.
  - After reset release, IDLE lasts exactly 1 cycle, then FETCH.
- All outputs are combinational from (state, instr, handshake inputs). No output depends on instr in IDLE or FETCH.
- IDLE: everything deasserted.
- FETCH:
  - imem_req = 1, held until imem_ready.
  - In the imem_ready cycle: ir_we = 1, next state DECODE.
- DECODE:
  - 1 cycle, no enables.
  - Opcode classified using the shared OPCODE_* defines.
  - Unknown opcode: next TRAP. Otherwise next EXEC.
- EXEC (1 cycle):
  - alu_src = 0 for R and B; 1 for all others.
  - alu_op: 00 for R, 10 for I-arith, 11 for B, 01 for everything else.
  - B: pc_we = 1; pc_sel = 01 if branch_taken, else 00; next FETCH.
  - LOAD/S: next MEM.
  - All others: next WB.
- MEM:
  - dmem_req = 1, held until dmem_ready; dmem_we = 1 for S, 0 for LOAD.
  - S: on ready, pc_we = 1, pc_sel = 00, next FETCH.
  - LOAD: on ready, next WB.
- WB (1 cycle):
  - reg_we = 1 unless instr[11:7] == 0.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - pc_we = 1; pc_sel: 01 for JAL, 10 for JALR, 00 otherwise.
  - Next FETCH.
- Invariants:
  - Exactly one pc_we pulse per retired instruction.
  - reg_we never asserts outside WB.
  - imem_req and dmem_req are never asserted together.
- Zero-wait latencies:
  - B: 3 cycles.
  - S, R, I-arith, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each ready wait adds 1 cycle.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each cycle without ready.
  - If it reaches TIMEOUT with ready still low: next FAULT, request dropped.
  - Ready arriving in the same cycle the count hits TIMEOUT wins, i.e. normal progress.
- TRAP / FAULT:
  - Terminal; exit only by reset.
  - illegal = 1 (TRAP) or fault = 1 (FAULT).
  - All requests and enables are 0.
- Reset mid-operation:
  - Immediate return to IDLE; outstanding requests drop asynchronously.
  - No enable pulses complete.
- A ready arriving while its req = 0 is ignored.

Test Plan:
- Reset, release, imem_ready tied high, instr = 0x00500093 (addi x1, x0, 5):
  - state sequence 0,1,2,3,5,1.
  - ir_we in cycle 2; in WB reg_we = 1, wb_sel = 00, pc_we = 1, pc_sel = 00; EXEC alu_op = 10, alu_src = 1.
- lw x2, 0(x1) with dmem_ready delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we = 0.
  - Then WB with wb_sel = 01, reg_we = 1; total 8 cycles FETCH-to-FETCH.
- beq, once with branch_taken = 1 and once with 0:
  - EXEC pc_we = 1, alu_op = 11, pc_sel = 01 / 00 respectively; reg_we never asserted; 3-cycle instruction.
- jalr x1, 0(x5): WB reg_we = 1, wb_sel = 10, pc_sel = 10. Then add x0, x1, x2: WB reg_we = 0, pc_we = 1.
- Illegal opcode 0x0000007F: TRAP after DECODE, illegal = 1, imem_req stays 0 for 20 cycles; rst_n pulse returns to IDLE with illegal = 0.
- imem_ready held low: fault = 1 and state = 7 after TIMEOUT cycles in FETCH. Separately, assert rst_n = 0 mid-MEM: dmem_req drops the same cycle without a clock edge.
